// File: rtl/pc_seq_unit.sv
// Program-counter unit for the multi-byte-instruction core.
// Holds the architectural PC, forms the sequential successor PC+len, and
// picks the next PC from sequential flow, a branch target, the interrupt
// vector or the saved interrupt return address. A single-level interrupt
// context (saved PC plus RUN/ISR state) lives here as well.
module pc_seq_unit #(
  parameter int          ADDR_W    = 16,
  parameter int          MAX_LEN   = 3,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h0000_0010,
  localparam int         LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [LEN_W-1:0]  instr_len,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              iret,
  input  logic              irq_req,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_seq,
  output logic [ADDR_W-1:0] epc_out,
  output logic              irq_ack,
  output logic              in_isr,
  output logic              wrap,
  output logic              len_err
);

  // Vector addresses reduced to the PC width once, so the datapath never
  // has to deal with the 32-bit parameter form.
  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] IRQ_PC   = ADDR_W'(IRQ_VEC);

  typedef enum logic {
    RUN = 1'b0,
    ISR = 1'b1
  } state_t;

  // An instruction length is usable only in the range 1..MAX_LEN.
  function automatic logic len_legal(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(MAX_LEN));
  endfunction

  // Sequential successor at one extra bit of width; the top bit is the
  // carry out of the address space and marks a wrap past 2^ADDR_W-1.
  function automatic logic [ADDR_W:0] seq_add(input logic [ADDR_W-1:0] pc,
                                               input logic [LEN_W-1:0]  len);
    return {1'b0, pc} + (ADDR_W + 1)'(len);
  endfunction

  // Registered architectural state (stage p1) and its next values (p0).
  logic [ADDR_W-1:0] pc_p1,  pc_p0;
  logic [ADDR_W-1:0] epc_p1, epc_p0;
  state_t            state_p1, state_p0;
  logic              irq_ack_p1, irq_ack_p0;
  logic              wrap_p1,    wrap_p0;
  logic              len_err_p1, len_err_p0;

  logic [ADDR_W:0]   seq_sum_p0;
  logic              len_ok_p0;
  logic              irq_take_p0;
  logic              iret_take_p0;

  // ---- stage p0: successor arithmetic and request qualification ----
  // Successor address and qualified requests for the current cycle.
  always_comb begin
    seq_sum_p0   = seq_add(pc_p1, instr_len);
    len_ok_p0    = len_legal(instr_len);
    irq_take_p0  = irq_req && (state_p1 == RUN);
    iret_take_p0 = iret && (state_p1 == ISR);
  end

  // Next-state / next-PC selection; first matching event wins.
  always_comb begin
    pc_p0      = pc_p1;
    epc_p0     = epc_p1;
    state_p0   = state_p1;
    irq_ack_p0 = 1'b0;
    wrap_p0    = 1'b0;
    len_err_p0 = 1'b0;
    if (!stall) begin
      if (irq_take_p0) begin
        // Interrupt beats a same-cycle branch; the return point is the
        // sequential successor even when the length is bogus.
        epc_p0     = seq_sum_p0[ADDR_W-1:0];
        pc_p0      = IRQ_PC;
        state_p0   = ISR;
        irq_ack_p0 = 1'b1;
      end else if (branch_taken) begin
        pc_p0 = branch_target;
      end else if (iret_take_p0) begin
        pc_p0    = epc_p1;
        state_p0 = RUN;
      end else if (!len_ok_p0) begin
        len_err_p0 = 1'b1;
      end else begin
        pc_p0   = seq_sum_p0[ADDR_W-1:0];
        wrap_p0 = seq_sum_p0[ADDR_W];
      end
    end
  end

  // ---- stage p1: architectural registers ----
  // State register; reset wins over stall and every request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p1      <= RESET_PC;
      epc_p1     <= '0;
      state_p1   <= RUN;
      irq_ack_p1 <= 1'b0;
      wrap_p1    <= 1'b0;
      len_err_p1 <= 1'b0;
    end else begin
      pc_p1      <= pc_p0;
      epc_p1     <= epc_p0;
      state_p1   <= state_p0;
      irq_ack_p1 <= irq_ack_p0;
      wrap_p1    <= wrap_p0;
      len_err_p1 <= len_err_p0;
    end
  end

  assign pc_out  = pc_p1;
  assign pc_seq  = seq_sum_p0[ADDR_W-1:0];
  assign epc_out = epc_p1;
  assign irq_ack = irq_ack_p1;
  assign in_isr  = (state_p1 == ISR);
  assign wrap    = wrap_p1;
  assign len_err = len_err_p1;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: a linear sequence of steps with
// hand-computed expected values checked by immediate assertions.
module tb_pc_seq_unit;

  localparam int ADDR_W = 16;
  localparam int LEN_W  = 2;

  logic              clk;
  logic              rst;
  logic              stall;
  logic [LEN_W-1:0]  instr_len;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              iret;
  logic              irq_req;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] epc_out;
  logic              irq_ack;
  logic              in_isr;
  logic              wrap;
  logic              len_err;

  int checks = 0;
  int errors = 0;

  pc_seq_unit #(
    .ADDR_W   (16),
    .MAX_LEN  (3),
    .RESET_VEC(32'h0000_0000),
    .IRQ_VEC  (32'h0000_0010)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .instr_len    (instr_len),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .iret         (iret),
    .irq_req      (irq_req),
    .pc_out       (pc_out),
    .pc_seq       (pc_seq),
    .epc_out      (epc_out),
    .irq_ack      (irq_ack),
    .in_isr       (in_isr),
    .wrap         (wrap),
    .len_err      (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; instr_len = '0; branch_taken = 1'b0;
    branch_target = '0; iret = 1'b0; irq_req = 1'b0;
    step();
    check("rst_pc",      32'(pc_out),  32'h0000);
    check("rst_epc",     32'(epc_out), 32'h0000);
    check("rst_isr",     32'(in_isr),  32'h0);
    check("rst_ack",     32'(irq_ack), 32'h0);
    check("rst_wrap",    32'(wrap),    32'h0);
    check("rst_len_err", 32'(len_err), 32'h0);

    // Sequential flow, 3-byte instructions
    rst = 1'b0; instr_len = 2'd3; #1;
    check("seq_pcseq0", 32'(pc_seq), 32'h0003);
    step(); check("seq_pc1", 32'(pc_out), 32'h0003); check("seq_wrap1", 32'(wrap), 32'h0);
    step(); check("seq_pc2", 32'(pc_out), 32'h0006);
    step(); check("seq_pc3", 32'(pc_out), 32'h0009);
    step(); check("seq_pc4", 32'(pc_out), 32'h000C);
    check("seq_pcseq4", 32'(pc_seq), 32'h000F);
    check("seq_wrap4",  32'(wrap),   32'h0);

    // Wrap past the top of the address space
    branch_taken = 1'b1; branch_target = 16'hFFFE;
    step(); check("br_pc", 32'(pc_out), 32'hFFFE);
    branch_taken = 1'b0; instr_len = 2'd3;
    step(); check("wrap_pc", 32'(pc_out), 32'h0001); check("wrap_set", 32'(wrap), 32'h1);
    step(); check("wrap_pc2", 32'(pc_out), 32'h0004); check("wrap_clr", 32'(wrap), 32'h0);

    // Interrupt entry, masking, return and re-entry
    branch_taken = 1'b1; branch_target = 16'h0040;
    step(); check("br40_pc", 32'(pc_out), 32'h0040);
    branch_taken = 1'b0; instr_len = 2'd2; irq_req = 1'b1; #1;
    check("irq_pcseq", 32'(pc_seq), 32'h0042);
    step();
    check("irq_pc",  32'(pc_out),  32'h0010);
    check("irq_epc", 32'(epc_out), 32'h0042);
    check("irq_ack", 32'(irq_ack), 32'h1);
    check("irq_isr", 32'(in_isr),  32'h1);
    step();
    check("mask_pc",  32'(pc_out),  32'h0012);
    check("mask_ack", 32'(irq_ack), 32'h0);
    check("mask_isr", 32'(in_isr),  32'h1);
    iret = 1'b1;
    step();
    check("iret_pc",  32'(pc_out), 32'h0042);
    check("iret_isr", 32'(in_isr), 32'h0);
    iret = 1'b0;
    step();
    check("reirq_pc",  32'(pc_out),  32'h0010);
    check("reirq_ack", 32'(irq_ack), 32'h1);
    check("reirq_epc", 32'(epc_out), 32'h0044);

    // Branch inside ISR is honoured
    irq_req = 1'b0; branch_taken = 1'b1; branch_target = 16'h1234;
    step();
    check("isrbr_pc",  32'(pc_out), 32'h1234);
    check("isrbr_isr", 32'(in_isr), 32'h1);
    branch_taken = 1'b0; iret = 1'b1;
    step(); check("iret2_pc", 32'(pc_out), 32'h0044);

    // Interrupt beats a same-cycle branch in RUN
    iret = 1'b0; branch_taken = 1'b1; branch_target = 16'h1234; irq_req = 1'b1;
    step();
    check("irqbr_pc",  32'(pc_out),  32'h0010);
    check("irqbr_epc", 32'(epc_out), 32'h0046);
    check("irqbr_ack", 32'(irq_ack), 32'h1);
    branch_taken = 1'b0; irq_req = 1'b0; iret = 1'b1;
    step(); check("iret3_pc", 32'(pc_out), 32'h0046);

    // Stall holds everything and does not take the interrupt
    iret = 1'b0; stall = 1'b1; irq_req = 1'b1; instr_len = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc",  32'(pc_out),  32'h0046);
      check("stall_ack", 32'(irq_ack), 32'h0);
      check("stall_isr", 32'(in_isr),  32'h0);
    end
    stall = 1'b0;
    step();
    check("unstall_pc",  32'(pc_out),  32'h0010);
    check("unstall_ack", 32'(irq_ack), 32'h1);
    check("unstall_epc", 32'(epc_out), 32'h0047);
    irq_req = 1'b0; iret = 1'b1;
    step(); check("iret4_pc", 32'(pc_out), 32'h0047);

    // iret while in RUN falls through to sequential flow
    step();
    check("iretrun_pc",  32'(pc_out), 32'h0048);
    check("iretrun_isr", 32'(in_isr), 32'h0);
    iret = 1'b0;

    // Illegal length holds the PC and flags len_err
    branch_taken = 1'b1; branch_target = 16'h0005;
    step(); check("br5_pc", 32'(pc_out), 32'h0005);
    branch_taken = 1'b0; instr_len = 2'd0;
    step();
    check("len0_pc",  32'(pc_out),  32'h0005);
    check("len0_err", 32'(len_err), 32'h1);
    instr_len = 2'd1;
    step();
    check("len1_pc",  32'(pc_out),  32'h0006);
    check("len1_err", 32'(len_err), 32'h0);

    // Interrupt with illegal length saves pc_seq and suppresses len_err
    instr_len = 2'd0; irq_req = 1'b1;
    step();
    check("irqlen_pc",  32'(pc_out),  32'h0010);
    check("irqlen_epc", 32'(epc_out), 32'h0006);
    check("irqlen_err", 32'(len_err), 32'h0);
    check("irqlen_ack", 32'(irq_ack), 32'h1);

    // Reset in the middle of an ISR
    irq_req = 1'b0; rst = 1'b1;
    step();
    check("rstisr_pc",  32'(pc_out),  32'h0000);
    check("rstisr_isr", 32'(in_isr),  32'h0);
    check("rstisr_epc", 32'(epc_out), 32'h0000);
    check("rstisr_ack", 32'(irq_ack), 32'h0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
